// File: rtl/compute_seq_pkg.sv
// compute_seq_pkg: state/error encodings shared by the compute sequencer files
package compute_seq_pkg;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SELECTING = 3'd1;
    localparam logic [2:0] ST_LAUNCH    = 3'd2;
    localparam logic [2:0] ST_EXECUTING = 3'd3;
    localparam logic [2:0] ST_DONE      = 3'd4;
    localparam logic [2:0] ST_FAULT     = 3'd5;
    typedef enum logic [2:0] {
        IDLE      = ST_IDLE,
        SELECTING = ST_SELECTING,
        LAUNCH    = ST_LAUNCH,
        EXECUTING = ST_EXECUTING,
        DONE      = ST_DONE,
        FAULT     = ST_FAULT
    } seq_state_t;
    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_SELECT  = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_ABORT   = 2'd3
    } seq_err_t;
endpackage

// File: rtl/compute_watchdog.sv
// compute_watchdog: flags the LIMIT-th consecutive enabled cycle since the last clear
module compute_watchdog #(
    parameter int LIMIT = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(LIMIT);
    logic [W-1:0] cnt;
    assign expired = enable && (cnt == W'(LIMIT - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable && !expired)
            cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/compute_sequencer.sv
// compute_sequencer: select/launch/execute control FSM; watchdog only with COMPUTE_SEQ_WATCHDOG_EN
module compute_sequencer
    import compute_seq_pkg::*;
#(
    parameter int ADDR_WIDTH     = 14,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  err_clear,
    input  logic                  sel_result_valid,
    input  logic                  sel_error,
    input  logic [ADDR_WIDTH-1:0] sel_bram_addr,
    output logic                  exe_start,
    input  logic                  exe_done,
    input  logic [ADDR_WIDTH-1:0] exe_bram_addr,
    output logic [ADDR_WIDTH-1:0] bram_rd_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            err_code,
    output logic [2:0]            state_o,
    output logic [CNT_WIDTH-1:0]  op_count
);
    seq_state_t state;
    seq_err_t   err;
    logic       expired;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

`ifdef COMPUTE_SEQ_WATCHDOG_EN
    // Counter is cleared during LAUNCH so it starts from zero on the first EXECUTING cycle
    compute_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (state == LAUNCH),
        .enable  (state == EXECUTING),
        .expired (expired)
    );
`else
    assign expired = 1'b0;
`endif

    assign state_o      = state;
    assign err_code     = err;
    assign bram_rd_addr = (state == LAUNCH || state == EXECUTING) ? exe_bram_addr : sel_bram_addr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            exe_start <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            err       <= ERR_NONE;
            op_count  <= '0;
        end else begin
            exe_start <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state <= SELECTING;
                    busy  <= 1'b1;
                end
                SELECTING: if (sel_error) begin
                    state <= FAULT;
                    busy  <= 1'b0;
                    error <= 1'b1;
                    err   <= ERR_SELECT;
                end else if (sel_result_valid) begin
                    state     <= LAUNCH;
                    exe_start <= 1'b1;
                end else if (abort) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                LAUNCH: state <= EXECUTING;
                EXECUTING: if (exe_done) begin
                    state <= DONE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    if (~&op_count)
                        op_count <= op_count + 1'b1;
                end else if (expired || abort) begin
                    state <= FAULT;
                    busy  <= 1'b0;
                    error <= 1'b1;
                    err   <= expired ? ERR_TIMEOUT : ERR_ABORT;
                end
                DONE: if (!start) begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                FAULT: if (err_clear) begin
                    state <= IDLE;
                    error <= 1'b0;
                    err   <= ERR_NONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/compute_sequencer.md
COMPUTE_SEQUENCER -- requirements
Module: compute_sequencer

Interface
REQ-001 Parameter ADDR_WIDTH, default 14: BRAM read-address width.
REQ-002 Parameter CNT_WIDTH, default 16: completed-operation counter width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000: executor watchdog limit in clk cycles, at least 2.
REQ-004 Port clk, input, 1: clock, rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port start, input, 1: level request to begin selection.
REQ-007 Port abort, input, 1: cancel the current operation.
REQ-008 Port err_clear, input, 1: acknowledge fault.
REQ-009 Port sel_result_valid, input, 1: selector finished; operands are valid.
REQ-010 Port sel_error, input, 1: selector rejected the operation.
REQ-011 Port sel_bram_addr, input, ADDR_WIDTH: selector read address.
REQ-012 Port exe_start, output, 1: one-cycle executor launch pulse.
REQ-013 Port exe_done, input, 1: executor completion pulse.
REQ-014 Port exe_bram_addr, input, ADDR_WIDTH: executor read address.
REQ-015 Port bram_rd_addr, output, ADDR_WIDTH: muxed BRAM read address.
REQ-016 Port busy, input/output as follows: output, 1, high in SELECTING, LAUNCH or EXECUTING.
REQ-017 Port done, output, 1: high in DONE.
REQ-018 Port error, output, 1: high in FAULT.
REQ-019 Port err_code, output, 2: fault cause (0 none, 1 select, 2 timeout, 3 abort).
REQ-020 Port state_o, output, 3: current state encoding.
REQ-021 Port op_count, output, CNT_WIDTH: count of completed operations.

Function
REQ-022 The FSM SHALL have six states: IDLE=0, SELECTING=1, LAUNCH=2, EXECUTING=3, DONE=4, FAULT=5.
REQ-023 IDLE SHALL go to SELECTING on start=1.
REQ-024 SELECTING transitions:
- sel_error=1 → FAULT, err_code=1.
- otherwise sel_result_valid=1 → LAUNCH.
- otherwise abort=1 → IDLE with no fault.
- sel_error has priority over sel_result_valid in the same cycle.
REQ-025 LAUNCH SHALL assert exe_start for exactly one cycle, then go unconditionally to EXECUTING; abort is ignored in LAUNCH.
REQ-026 EXECUTING transitions, in priority order:
- exe_done=1 → DONE, op_count increments, saturating at all-ones.
- watchdog expiry → FAULT, err_code=2.
- abort=1 → FAULT, err_code=3.
REQ-027 The watchdog SHALL clear on entry to EXECUTING and expire when EXECUTING has lasted TIMEOUT_CYCLES cycles without exe_done; exe_done in the expiry cycle wins.
REQ-028 DONE SHALL hold until start=0, then go to IDLE; a held start SHALL NOT retrigger.
REQ-029 FAULT SHALL hold error and err_code until err_clear=1, then go to IDLE with err_code=0.
REQ-030 bram_rd_addr SHALL be combinational: exe_bram_addr in LAUNCH or EXECUTING, sel_bram_addr in all other states.
REQ-031 exe_done or sel_* pulses arriving in states that do not consume them SHALL be ignored.

Reset
REQ-032 On rst_n=0, outputs SHALL asynchronously take these values: state IDLE, exe_start=0, busy=0, done=0, error=0, err_code=0, op_count=0, watchdog=0; reset mid-operation aborts silently.

Configuration
REQ-033 With macro COMPUTE_SEQ_WATCHDOG_EN defined, the watchdog of REQ-027 SHALL be present.
REQ-034 With COMPUTE_SEQ_WATCHDOG_EN undefined, there SHALL be no watchdog logic, err_code=2 SHALL never occur, and EXECUTING SHALL wait indefinitely.

Structure
REQ-035 Package compute_seq_pkg SHALL hold the seq_state_t enum, the seq_err_t enum (ERR_NONE, ERR_SELECT, ERR_TIMEOUT, ERR_ABORT) and the state-encoding constants.
REQ-036 The watchdog SHALL be sub-module compute_watchdog with inputs clear and enable and output expired, instantiated only under the macro.

Verification
REQ-037 Nominal: start=1; sel_result_valid at cycle 5; exe_done 20 cycles after exe_start → exactly one exe_start pulse, done=1, op_count=1; after start=0 → IDLE.
REQ-038 Select error: sel_error=1 and sel_result_valid=1 in the same cycle → FAULT, err_code=1, no exe_start; err_clear → IDLE, err_code=0.
REQ-039 Timeout: TIMEOUT_CYCLES=8, no exe_done → FAULT with err_code=2 after 8 cycles in EXECUTING; second run with exe_done in cycle 8 → DONE.
REQ-040 Abort: abort in SELECTING → IDLE with error=0; abort in EXECUTING → FAULT with err_code=3; abort together with exe_done → DONE.
REQ-041 Mux and saturation: bram_rd_addr equals sel_bram_addr=0x0123 in SELECTING and exe_bram_addr=0x2ABC in EXECUTING; with CNT_WIDTH=2, 5 completions → op_count=3.
REQ-042 Reset: rst_n pulsed low mid-EXECUTING → all outputs at their REQ-032 values immediately, without waiting for a clock edge.
